// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared rv32i pipeline types: machine word, register index, packed control word.
package rv32i_types;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 32;

  typedef logic [XLEN-1:0]      rv32i_word;
  typedef logic [REG_IDX_W-1:0] rv32i_reg;
  typedef logic [CTRL_W-1:0]    rv32i_ctrl_t;

  localparam rv32i_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_reg_bypass.sv
// Writeback-to-operand select: substitutes wb_data when MEM/WB writes the indexed register (never x0).
module operand_bypass
  import rv32i_types::*;
(
  input  logic      wb_load,
  input  rv32i_reg  wb_rd,
  input  rv32i_word wb_data,
  input  rv32i_reg  rs,
  input  rv32i_word rs_data,
  output rv32i_word data
);

  logic hit;

  always_comb begin
    hit  = wb_load && (wb_rd != '0) && (wb_rd == rs);
    data = hit ? wb_data : rs_data;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: capture, hold on stall, bubble/flush squash, writeback bypass and bubble counter.
module id_ex_pipe_reg
  import rv32i_types::*;
#(
  parameter int CW_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [31:0]          id_pc,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_rd,
  input  logic [31:0]          id_rs1_data,
  input  logic [31:0]          id_rs2_data,
  input  logic [31:0]          id_imm,
  input  logic [CW_WIDTH-1:0]  id_ctrl,
  input  logic                 wb_load,
  input  logic [4:0]           wb_rd,
  input  logic [31:0]          wb_data,
  output logic                 ex_valid,
  output logic [31:0]          ex_pc,
  output logic [31:0]          ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [31:0]          ex_rs1_data,
  output logic [31:0]          ex_rs2_data,
  output logic [CW_WIDTH-1:0]  ex_ctrl,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  logic                 vld_p0, vld_p1;
  rv32i_word            pc_p0, pc_p1, imm_p0, imm_p1;
  rv32i_reg             rs1_p0, rs1_p1, rs2_p0, rs2_p1, rd_p0, rd_p1;
  rv32i_word            rs1_data_p0, rs1_data_p1, rs2_data_p0, rs2_data_p1;
  logic [CW_WIDTH-1:0]  ctrl_p0, ctrl_p1;
  logic [CNT_WIDTH-1:0] cnt_p0, cnt_p1;

  rv32i_word ld_rs1_data, ld_rs2_data, rf_rs1_data, rf_rs2_data;

  operand_bypass u_ld_rs1 (.wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
                           .rs(id_rs1), .rs_data(id_rs1_data), .data(ld_rs1_data));
  operand_bypass u_ld_rs2 (.wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
                           .rs(id_rs2), .rs_data(id_rs2_data), .data(ld_rs2_data));
  operand_bypass u_rf_rs1 (.wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
                           .rs(rs1_p1), .rs_data(rs1_data_p1), .data(rf_rs1_data));
  operand_bypass u_rf_rs2 (.wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
                           .rs(rs2_p1), .rs_data(rs2_data_p1), .data(rf_rs2_data));

  always_comb begin
    vld_p0      = vld_p1;
    pc_p0       = pc_p1;
    imm_p0      = imm_p1;
    rs1_p0      = rs1_p1;
    rs2_p0      = rs2_p1;
    rd_p0       = rd_p1;
    rs1_data_p0 = rs1_data_p1;
    rs2_data_p0 = rs2_data_p1;
    ctrl_p0     = ctrl_p1;
    cnt_p0      = cnt_p1;
    if (stall) begin
      // A held entry still picks up MEM/WB results so it cannot go stale.
      if (vld_p1) begin
        rs1_data_p0 = rf_rs1_data;
        rs2_data_p0 = rf_rs2_data;
      end
    end else if (flush || bubble) begin
      vld_p0      = 1'b0;
      pc_p0       = '0;
      imm_p0      = '0;
      rs1_p0      = '0;
      rs2_p0      = '0;
      rd_p0       = '0;
      rs1_data_p0 = '0;
      rs2_data_p0 = '0;
      ctrl_p0     = CW_WIDTH'(CTRL_NOP);
      if (!flush) cnt_p0 = cnt_p1 + CNT_WIDTH'(1);
    end else begin
      vld_p0      = id_valid;
      pc_p0       = id_pc;
      imm_p0      = id_imm;
      rs1_p0      = id_rs1;
      rs2_p0      = id_rs2;
      rd_p0       = id_rd;
      rs1_data_p0 = ld_rs1_data;
      rs2_data_p0 = ld_rs2_data;
      ctrl_p0     = id_valid ? id_ctrl : CW_WIDTH'(CTRL_NOP);
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      ctrl_p1     <= '0;
      cnt_p1      <= '0;
    end else begin
      vld_p1      <= vld_p0;
      pc_p1       <= pc_p0;
      imm_p1      <= imm_p0;
      rs1_p1      <= rs1_p0;
      rs2_p1      <= rs2_p0;
      rd_p1       <= rd_p0;
      rs1_data_p1 <= rs1_data_p0;
      rs2_data_p1 <= rs2_data_p0;
      ctrl_p1     <= ctrl_p0;
      cnt_p1      <= cnt_p0;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_pc        = pc_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs1       = rs1_p1;
  assign ex_rs2       = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_rs1_data  = rs1_data_p1;
  assign ex_rs2_data  = rs2_data_p1;
  assign ex_ctrl      = ctrl_p1;
  assign bubble_count = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; a 4-bit bubble counter makes the wrap reachable.
module tb_id_ex_pipe_reg;

  localparam int CW  = 32;
  localparam int CNT = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           stall, bubble, flush, id_valid, wb_load;
  logic [31:0]    id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]     id_rs1, id_rs2, id_rd, wb_rd;
  logic [CW-1:0]  id_ctrl;
  logic           ex_valid;
  logic [31:0]    ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]     ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0]  ex_ctrl;
  logic [CNT-1:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CW_WIDTH(CW), .CNT_WIDTH(CNT)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic           v;
    logic [31:0]    pc;
    logic [4:0]     rs1, rs2, rd;
    logic [31:0]    d1, d2, imm;
    logic [CW-1:0]  ctrl;
    logic [CNT-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic exp_t mk(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] imm, logic [CW-1:0] ctrl, logic [CNT-1:0] cnt);
    exp_t e;
    e.v = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t actual();
    return mk(ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
              ex_imm, ex_ctrl, bubble_count);
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("v=%0b pc=%h rs1=%0d rs2=%0d rd=%0d d1=%h d2=%h imm=%h ctrl=%h cnt=%0d",
                     e.v, e.pc, e.rs1, e.rs2, e.rd, e.d1, e.d2, e.imm, e.ctrl, e.cnt);
  endfunction

  // Monitor: one registered snapshot per negedge for every edge the stimulus issued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %s expected %s", nm, fmt(a), fmt(e));
      end
    end
  end

  task automatic tick(string nm, exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic clr_in();
    stall = 0; bubble = 0; flush = 0; id_valid = 0; wb_load = 0;
    id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_ctrl = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                        logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                        logic [31:0] imm, logic [CW-1:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic chk_zero(string nm);
    exp_t a;
    a = actual();
    n_tests++;
    if (a !== '0) begin
      n_fail++;
      $display("FAIL %s: got %s expected all zero", nm, fmt(a));
    end
  endtask

  exp_t held;
  exp_t zero_e;

  initial begin
    zero_e = '0;
    clr_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    set_id(1, 32'h40, 1, 2, 3, 32'h11, 32'h22, 32'h4, 32'h13);
    tick("load_40", mk(1, 32'h40, 1, 2, 3, 32'h11, 32'h22, 32'h4, 32'h13, 0));
    #2 rst_n = 0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    clr_in();
    rst_n = 1;

    set_id(1, 32'h100, 3, 7, 6, 32'hAAAA5555, 32'h22222222, 32'h10, 32'h13);
    held = mk(1, 32'h100, 3, 7, 6, 32'hAAAA5555, 32'h22222222, 32'h10, 32'h13, 0);
    tick("load_100", held);

    set_id(1, 32'h200, 9, 10, 11, 32'h99, 32'h98, 32'h20, 32'h55);
    stall = 1;
    tick("stall_only", held);
    flush = 1;
    tick("stall_flush", held);
    flush = 0; bubble = 1;
    tick("stall_bubble", held);
    bubble = 0;

    wb_load = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
    held.d2 = 32'hDEADBEEF;
    tick("refresh_rs2", held);
    wb_rd = 9; wb_data = 32'h5;
    tick("refresh_nomatch", held);
    wb_rd = 3; wb_data = 32'h31;
    held.d1 = 32'h31;
    tick("refresh_rs1", held);
    wb_load = 0; wb_rd = 0; wb_data = 0; stall = 0;

    set_id(1, 32'h200, 5, 6, 7, 32'h1, 32'h2, 32'h3, 32'hFFFFFFFF);
    bubble = 1;
    tick("bubble_1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick("bubble_2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    flush = 1;
    tick("flush_bubble", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    flush = 0; bubble = 0;

    set_id(1, 32'h300, 1, 2, 4, 32'hA, 32'hB, 32'hC, 32'h77);
    tick("load_300", mk(1, 32'h300, 1, 2, 4, 32'hA, 32'hB, 32'hC, 32'h77, 2));
    flush = 1;
    tick("flush", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    flush = 0;

    set_id(1, 32'h400, 5, 5, 1, 32'h1111, 32'h2222, 32'h4, 32'h33);
    wb_load = 1; wb_rd = 5; wb_data = 32'h1234;
    tick("bypass_both", mk(1, 32'h400, 5, 5, 1, 32'h1234, 32'h1234, 32'h4, 32'h33, 2));
    set_id(1, 32'h404, 0, 0, 1, 32'h1111, 32'h2222, 32'h4, 32'h33);
    wb_rd = 0;
    tick("bypass_x0", mk(1, 32'h404, 0, 0, 1, 32'h1111, 32'h2222, 32'h4, 32'h33, 2));
    set_id(1, 32'h408, 8, 9, 2, 32'h8888, 32'h9999, 32'h8, 32'h44);
    wb_rd = 9; wb_data = 32'hCAFE;
    tick("bypass_rs2", mk(1, 32'h408, 8, 9, 2, 32'h8888, 32'hCAFE, 32'h8, 32'h44, 2));
    wb_load = 0;
    tick("no_wb_load", mk(1, 32'h408, 8, 9, 2, 32'h8888, 32'h9999, 32'h8, 32'h44, 2));
    wb_rd = 0; wb_data = 0;

    set_id(0, 32'h500, 2, 3, 4, 32'h5, 32'h6, 32'h7, 32'hFF);
    held = mk(0, 32'h500, 2, 3, 4, 32'h5, 32'h6, 32'h7, 32'h0, 2);
    tick("invalid_load", held);
    stall = 1; wb_load = 1; wb_rd = 2; wb_data = 32'hBAD;
    tick("no_refresh_invalid", held);
    stall = 0; wb_load = 0; wb_rd = 0; wb_data = 0;

    bubble = 1;
    for (int i = 0; i < 14; i++)
      tick($sformatf("wrap_%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CNT'(3 + i)));
    bubble = 0;

    set_id(1, 32'h600, 4, 5, 6, 32'h44, 32'h55, 32'h66, 32'h99);
    tick("load_600", mk(1, 32'h600, 4, 5, 6, 32'h44, 32'h55, 32'h66, 32'h99, 0));
    stall = 1;
    #2 rst_n = 0;
    #1 chk_zero("reset_mid_stall");
    @(negedge clk);
    rst_n = 1;
    tick("stall_after_reset", zero_e);
    stall = 0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the five-stage rv32i pipeline; sits between decode and execute.
- Consumes the stall/bubble outputs of the forwarding/hazard unit.
- Provides the rs1/rs2 indices and operand data that the hazard unit compares against EX/MEM and MEM/WB destinations.
- Captures decode outputs, holds them on stall, inserts bubbles, squashes on flush, bypasses same-cycle writeback into captured operands, and counts bubble cycles.

Parameters:
- CW_WIDTH, 32, width of the packed control word (rv32i_ctrl_t).
- CNT_WIDTH, 32, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all contents (EX/MEM backpressure, cache miss)
- bubble  in  1  stall_id_ex from hazard unit; load a NOP
- flush  in  1  squash entry (branch/jump redirect)
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  decode PC
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  32 each  regfile read data
- id_imm  in  32  decoded immediate
- id_ctrl  in  CW_WIDTH  control word
- wb_load  in  1  MEM/WB regfile write enable
- wb_rd  in  5  MEM/WB destination
- wb_data  in  32  MEM/WB write data
- ex_valid  out  1  entry valid
- ex_pc, ex_imm  out  32 each
- ex_rs1, ex_rs2, ex_rd  out  5 each
- ex_rs1_data, ex_rs2_data  out  32 each
- ex_ctrl  out  CW_WIDTH
- bubble_count  out  CNT_WIDTH  cycles in which a bubble was inserted

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0 and ex_valid=0.
  - bubble_count=0.
  - Deassertion takes effect at the next clk edge. Reset mid-stall discards the held entry.
- Per-edge priority: stall > flush > bubble > load.
- stall=1: every field holds, and bubble_count holds. A flush or bubble asserted in the same cycle is ignored; the sources keep them asserted until stall drops.
- flush=1 (no stall): ex_valid<=0 and ex_ctrl<=0. Other fields don't care; implementation loads them as 0.
- bubble=1 (no stall, no flush):
  - ex_valid<=0 and ex_ctrl<=0, so regfile write, mem_read and mem_write are all 0.
  - Index fields load 0, so no forwarding match against a bubble.
  - bubble_count increments by 1 and wraps modulo 2^CNT_WIDTH.
- Load (none asserted):
  - All ex_* fields <= id_* fields, with ex_valid<=id_valid.
  - If id_valid=0, ex_ctrl<=0 regardless of id_ctrl.
- Latency: 1 cycle from id_* to ex_*.
- Writeback bypass on load:
  - If wb_load=1, wb_rd!=0 and wb_rd==id_rs1, then ex_rs1_data<=wb_data instead of id_rs1_data. Same rule for rs2.
  - Both operands may bypass in the same cycle.
  - x0 is never bypassed.
- Writeback refresh on hold:
  - While stall=1 and ex_valid=1, a wb_load to a nonzero wb_rd matching ex_rs1 (or ex_rs2) overwrites the held ex_rs1_data (or ex_rs2_data) with wb_data.
  - This prevents stale operands after MEM/WB retires during a partial stall.
  - All other fields still hold.
- Operand data out is purely registered (no combinational input-to-output paths).
- Single always_ff for state; next-state logic in always_comb.

Decomposition:
- Shared package rv32i_types:
  - rv32i_word (32b), rv32i_reg (5b), rv32i_ctrl_t (packed, CW_WIDTH).
  - Constant CTRL_NOP = '0.
- Natural sub-module: operand_bypass. Combinational compare/select of wb_rd/wb_data against a register index, with x0 guard. Instantiated twice for load and twice for refresh (or shared with a mux).

Test Plan:
- Reset: drive rst_n low mid-cycle with id_valid=1 and id_pc=0x40 loaded -> all outputs 0 immediately (asynchronously), bubble_count=0.
- Load then stall:
  - Load id_pc=0x100, id_rs1=3, id_rs1_data=0xAAAA5555 -> next cycle ex_pc=0x100, ex_rs1_data=0xAAAA5555.
  - Assert stall 3 cycles with new id_* values -> outputs unchanged.
- Bubble:
  - bubble=1 for 2 cycles with id_ctrl=0xFFFFFFFF -> ex_valid=0, ex_ctrl=0, ex_rs1=0, bubble_count=2.
  - bubble+stall together -> bubble_count unchanged.
- Bypass on load:
  - id_rs1=5, id_rs2=5, wb_load=1, wb_rd=5, wb_data=0x1234 -> both ex_rs*_data=0x1234.
  - Same stimulus with wb_rd=0 and id_rs1=0 -> regfile data passes unmodified.
- Refresh on hold:
  - Held entry ex_rs2=7 during stall; wb_load=1, wb_rd=7, wb_data=0xDEADBEEF -> ex_rs2_data=0xDEADBEEF, other fields unchanged.
- Priority and wrap:
  - flush+bubble -> bubble_count not incremented.
  - stall+flush -> entry preserved.
  - Preload counter to 0xFFFFFFFF, then one bubble -> bubble_count=0.
